seq_divider: RTL and testbench

- Iterative radix-2 restoring divider: WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient and remainder.
- Inverse companion to the team's multiplier blocks; used where a product must be divided back down, for example in scaling or normalisation datapaths.
- Valid/ready handshake on both input and output.
- One operation in flight at a time.

---
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider with valid/ready handshakes.
//   One quotient bit is produced per CALC cycle (WIDTH cycles per operation).
//   A zero divisor bypasses the iteration and returns quotient=all ones,
//   remainder=dividend with div_by_zero set.
//
// Optional build macro: SEQ_DIVIDER_SIGNED_EN
//   When defined, adds the is_signed input. Signed operations divide the
//   operand magnitudes and apply the sign fix-up on the last CALC edge, so
//   latency matches the unsigned path. Quotient truncates toward zero and the
//   remainder takes the sign of the dividend.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands present
//   in_ready     block can accept operands (registered)
//   dividend     numerator, sampled on input handshake
//   divisor      denominator, sampled on input handshake
//   is_signed    (SEQ_DIVIDER_SIGNED_EN only) two's complement operands
//   out_valid    result present (registered)
//   out_ready    consumer accepts result
//   quotient     result quotient (registered)
//   remainder    result remainder (registered)
//   div_by_zero  result came from a zero divisor (registered)

module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               signed_op;
  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   shifted_rem;
  logic [WIDTH-1:0]   iter_rem, iter_quo;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign signed_op = is_signed;
`else
  assign signed_op = 1'b0;
`endif

  // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which reads correctly as unsigned.
  always_comb begin
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
  end

  // One restoring step: shift {rem, quo} left, trial-subtract on WIDTH+1 bits.
  always_comb begin
    shifted_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    trial       = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    iter_rem    = trial[WIDTH] ? shifted_rem : trial[WIDTH-1:0];
    iter_quo    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d   = DONE;
            quo_d     = '1;
            rem_d     = dividend;
            dbz_d     = 1'b1;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            state_d   = CALC;
            rem_d     = '0;
            quo_d     = dvd_mag;
            dvs_d     = dvs_mag;
            cnt_d     = CNT_W'(WIDTH - 1);
            dbz_d     = 1'b0;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
          end
        end
      end

      CALC: begin
        rem_d = iter_rem;
        quo_d = iter_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Last iteration: sign fix-up folds into this edge.
          state_d = DONE;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          quo_d   = neg_quo_q ? (~iter_quo + WIDTH'(1)) : iter_quo;
          rem_d   = neg_rem_q ? (~iter_rem + WIDTH'(1)) : iter_rem;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): the driver pushes hand-computed
// expected results on each input handshake; a monitor pops and compares on
// every output handshake and checks latency, busy in_ready and output hold.

module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic         is_signed;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_results = 0;
  int out_hs_cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           hs;
  } exp_t;

  exp_t sb[$];

  logic         prev_ov = 1'b0;
  logic         prev_or = 1'b0;
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_dbz;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Cycle i spans from posedge i to posedge i+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        check("result_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0)
          check("latency", 32'(cyc - sb[0].hs), sb[0].dbz ? 32'd1 : 32'(W + 1));
      end
      if (out_valid && prev_ov && !prev_or) begin
        check("hold_quotient", 32'(quotient), 32'(prev_q));
        check("hold_remainder", 32'(remainder), 32'(prev_r));
        check("hold_dbz", 32'(div_by_zero), 32'(prev_dbz));
      end
      if (out_valid)
        check("in_ready_while_done", 32'(in_ready), 32'd0);
      else if (sb.size() > 0)
        check("in_ready_while_calc", 32'(in_ready), 32'd0);
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        n_results++;
        out_hs_cyc = cyc;
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_q   = quotient;
      prev_r   = remainder;
      prev_dbz = div_by_zero;
    end
  end

  // Presents operands from just after a posedge; returns just after the handshake edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                      input bit hold, output int hs_cyc);
    bit got;
    exp_t e;
    got = 1'b0;
    hs_cyc = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
    is_signed = sg;
`else
    if (sg) $display("note: signed vector run without signed build");
`endif
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        hs_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (got) begin
      e.q = eq; e.r = er; e.dbz = ed; e.hs = hs_cyc;
      sb.push_back(e);
    end else begin
      check("handshake_timeout", 32'd0, 32'd1);
    end
    if (!hold || !got) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, nres;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    dividend = '0;
    divisor = '0;
    out_ready = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;

    // Basic divide and latency.
    send(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, h1);
    wait_idle();

    // Back-to-back with in_valid held high across both operations.
    send(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b1, h1);
    send(8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0, h2);
    check("b2b_gap_after_out_hs", 32'(h2 - out_hs_cyc), 32'd1);
    check("b2b_throughput", 32'(h2 - h1), 32'(W + 2));
    wait_idle();

    // Divide by zero, then a normal divide.
    send(8'd13, 8'd0, 1'b0, 8'hFF, 8'd13, 1'b1, 1'b0, h1);
    send(8'd10, 8'd3, 1'b0, 8'd3, 8'd1, 1'b0, 1'b0, h1);
    wait_idle();

    // Output back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    nres = n_results;
    send(8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0, h1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_out_valid_seen", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    check("stall_no_early_pop", 32'(n_results - nres), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check("stall_single_handshake", 32'(n_results - nres), 32'd1);

    // Reset during CALC discards the operation.
    send(8'd77, 8'd5, 1'b0, 8'd15, 8'd2, 1'b0, 1'b0, h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_quotient", 32'(quotient), 32'd0);
    check("midreset_remainder", 32'(remainder), 32'd0);
    check("midreset_dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_stale_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'd9, 8'd2, 1'b0, 8'd4, 8'd1, 1'b0, 1'b0, h1);
    wait_idle();

    // Boundary vectors.
    send(8'd0, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, h1);
    send(8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, h1);
    send(8'd254, 8'd16, 1'b0, 8'd15, 8'd14, 1'b0, 1'b0, h1);
    send(8'd3, 8'd200, 1'b0, 8'd0, 8'd3, 1'b0, 1'b0, h1);
    wait_idle();

`ifdef SEQ_DIVIDER_SIGNED_EN
    send(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, h1);
    send(8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b0, h1);
    send(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, h1);
    send(8'hF9, 8'h00, 1'b1, 8'hFF, 8'hF9, 1'b1, 1'b0, h1);
    send(8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0, 1'b0, h1);
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
